alu_arbiter_seq: RTL and testbench

Sequencer and arbiter that shares the single combinational 16-bit ALU (inputs A, B, ctl; outputs R, S, exception) between two requesters.
- Grants one request at a time, round-robin.
- Holds operands on the ALU for an opcode-dependent number of cycles, so multi-cycle MUL/DIV paths settle.
- Captures R/S/exception and returns them over a valid/ready response channel tagged with the requester id.
- Sits between the execute-stage issue logic and the ALU instance.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_arbiter_seq_rr_arb2.sv | 37 +++
 rtl/alu_arbiter_seq.sv | 116 +++++++++++
 tb/tb_alu_arbiter_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, latency lookup and sequencer state encoding
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_AND = 4'b1101;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SLR = 4'b1011;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] ctl);
    case (ctl)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL,
      OP_DIV, OP_SLL, OP_SLR, OP_ROL, OP_ROR: is_legal_op = 1'b1;
      default:                                is_legal_op = 1'b0;
    endcase
  endfunction

  // Illegal codes still occupy the ALU for one cycle so they answer quickly.
  function automatic logic [3:0] op_latency(input logic [3:0] ctl,
                                            input logic [3:0] muldiv_cycles,
                                            input logic [3:0] simple_cycles);
    if (ctl == OP_MUL || ctl == OP_DIV) op_latency = muldiv_cycles;
    else if (is_legal_op(ctl))          op_latency = simple_cycles;
    else                                op_latency = 4'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_seq_rr_arb2.sv
// rtl/alu_arbiter_seq_rr_arb2.sv - two-requester round-robin grant with priority register
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_id
);

  logic prio;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = !prio;
        gnt1 = prio;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_id = gnt1;

  // After a grant the loser of any future tie is the requester just served.
  always_ff @(posedge clk) begin
    if (rst)              prio <= 1'b0;
    else if (gnt0 || gnt1) prio <= gnt0;
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// rtl/alu_arbiter_seq.sv - shares one combinational ALU between two requesters, round-robin
module alu_arbiter_seq
  import alu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int MULDIV_CYCLES = 4,
  parameter int SIMPLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_r,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_exc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_r,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_exc,
  output logic             busy
);

  seq_state_t       state, state_next;
  logic [3:0]       cnt;
  logic             gnt0, gnt1, gnt_id, grant;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_ctl;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == ST_IDLE),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt_id (gnt_id)
  );

  assign grant      = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign sel_a      = gnt_id ? req1_a   : req0_a;
  assign sel_b      = gnt_id ? req1_b   : req0_b;
  assign sel_ctl    = gnt_id ? req1_ctl : req0_ctl;
  assign rsp_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant)          state_next = ST_EXEC;
      ST_EXEC: if (cnt == 4'd0)    state_next = ST_DONE;
      ST_DONE: if (rsp_ready)      state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_ctl <= 4'd0;
      rsp_id  <= 1'b0;
      rsp_r   <= '0;
      rsp_s   <= '0;
      rsp_exc <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_ctl <= sel_ctl;
            rsp_id  <= gnt_id;
            cnt     <= op_latency(sel_ctl, 4'(MULDIV_CYCLES), 4'(SIMPLE_CYCLES)) - 4'd1;
          end
        end
        ST_EXEC: begin
          // Illegal codes never trust the ALU outputs; they report a bare exception.
          if (cnt == 4'd0) begin
            if (is_legal_op(alu_ctl)) begin
              rsp_r   <= alu_r;
              rsp_s   <= alu_s;
              rsp_exc <= alu_exc;
            end else begin
              rsp_r   <= '0;
              rsp_s   <= '0;
              rsp_exc <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb/tb_alu_arbiter_seq.sv - self-checking bench for alu_arbiter_seq with settling ALU model
module tb_alu_arbiter_seq;

  localparam int W  = 16;
  localparam int MD = 4;
  localparam int SC = 1;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_ctl, req1_ctl;
  logic rsp_valid, rsp_ready, rsp_id, rsp_exc, busy, alu_exc;
  logic [W-1:0] rsp_r, rsp_s, alu_a, alu_b, alu_r, alu_s;
  logic [3:0] alu_ctl;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.WIDTH(W), .MULDIV_CYCLES(MD), .SIMPLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_s(rsp_s), .rsp_exc(rsp_exc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_r(alu_r), .alu_s(alu_s), .alu_exc(alu_exc),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Returns {exc, s, r} of the shared ALU.
  function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [3:0]  n;
    logic [15:0] r, s;
    logic        e;
    r = '0; s = '0; e = 1'b0; n = b[3:0]; p = '0;
    case (c)
      4'hF: begin p = 32'(a) + 32'(b); r = p[15:0]; s = {15'b0, p[16]}; end
      4'hE: begin r = a - b; s = {15'b0, a < b}; end
      4'hD: r = a & b;
      4'hC: r = a | b;
      4'h1: begin p = 32'(a) * 32'(b); r = p[15:0]; s = p[31:16]; end
      4'h2: if (b == 16'd0) begin r = 16'hFFFF; s = a; e = 1'b1; end
            else begin r = a / b; s = a % b; end
      4'hA: r = a << n;
      4'hB: r = a >> n;
      4'h9: r = (a << n) | (a >> (16 - n));
      4'h8: r = (a >> n) | (a << (16 - n));
      default: begin r = 16'hA5A5; s = 16'h5A5A; end
    endcase
    return {e, s, r};
  endfunction

  function automatic bit legal(input logic [3:0] c);
    return (c >= 4'h8) || (c == 4'h1) || (c == 4'h2);
  endfunction

  function automatic int lat(input logic [3:0] c);
    if (c == 4'h1 || c == 4'h2) return MD;
    if (legal(c)) return SC;
    return 1;
  endfunction

  function automatic logic [32:0] expect_rsp(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    return legal(c) ? alu_fn(c, a, b) : {1'b1, 32'h0};
  endfunction

  // ALU model: MUL/DIV outputs are garbage until operands have been held long enough.
  logic [35:0] last_ops = '0;
  int held = 0;
  int settled, need;
  always @(posedge clk) begin
    if ({alu_a, alu_b, alu_ctl} == last_ops) held <= held + 1;
    else held <= 1;
    last_ops <= {alu_a, alu_b, alu_ctl};
  end
  always_comb begin
    settled = ({alu_a, alu_b, alu_ctl} == last_ops) ? held + 1 : 1;
    need = (alu_ctl == 4'h1 || alu_ctl == 4'h2) ? MD : 1;
    if (settled >= need) {alu_exc, alu_s, alu_r} = alu_fn(alu_ctl, alu_a, alu_b);
    else                 {alu_exc, alu_s, alu_r} = {1'b1, 16'hBAD0, 16'hBAD0};
  end

  task automatic drive_req(input bit id, input logic v, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    if (id == 1'b0) begin req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b; end
    else            begin req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_req(0, 0, 4'h0, 16'h0, 16'h0);
    drive_req(1, 0, 4'h0, 16'h0, 16'h0);
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    int k;
    @(negedge clk);
    drive_req(id, 1, c, a, b);
    #1;
    k = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("ready_wait", k, 0);
    @(posedge clk);
    @(negedge clk);
    drive_req(id, 0, c, a, b);
  endtask

  task automatic wait_rsp(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b, output int cyc);
    cyc = 1;
    #1;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      chk("alu_hold", {alu_ctl, alu_a, alu_b}, {c, a, b});
      @(negedge clk); #1; cyc++;
    end
    chk("rsp_wait", rsp_valid, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit id; logic [3:0] ctl; logic [15:0] a, b, r, s; logic exc;
  } vec_t;
  vec_t vt[13];

  bit m_idle, m_prio, m_pend, m_id, e0, e1;
  int due;
  logic [32:0] m_exp;

  initial begin
    int cyc, g[$], gc[$], rid[$], rr[$];
    bit drop;
    int eg[3];
    int er[3];

    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(0, 0, 4'h0, 16'h0, 16'h0);
    drive_req(1, 0, 4'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_id, rsp_exc, rsp_r, rsp_s}, 0);
    chk("rst_alu", {alu_ctl, alu_a, alu_b}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    rst = 1'b0;

    vt[0]  = '{0, 4'hF, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 1'b0};
    vt[1]  = '{1, 4'h1, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0};
    vt[2]  = '{0, 4'h2, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vt[3]  = '{1, 4'h2, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vt[4]  = '{0, 4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1};
    vt[5]  = '{1, 4'h7, 16'h0F0F, 16'h0003, 16'h0000, 16'h0000, 1'b1};
    vt[6]  = '{0, 4'hE, 16'h0005, 16'h0007, 16'hFFFE, 16'h0001, 1'b0};
    vt[7]  = '{1, 4'hA, 16'h0001, 16'h0004, 16'h0010, 16'h0000, 1'b0};
    vt[8]  = '{0, 4'h8, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 1'b0};
    vt[9]  = '{1, 4'h9, 16'h8001, 16'h0004, 16'h0018, 16'h0000, 1'b0};
    vt[10] = '{0, 4'h1, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0};
    vt[11] = '{1, 4'hD, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0};
    vt[12] = '{0, 4'hB, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0};

    for (int i = 0; i < 13; i++) begin
      issue(vt[i].id, vt[i].ctl, vt[i].a, vt[i].b);
      wait_rsp(vt[i].ctl, vt[i].a, vt[i].b, cyc);
      chk($sformatf("v%0d_latency", i), cyc, lat(vt[i].ctl) + 1);
      chk($sformatf("v%0d_id", i), rsp_id, vt[i].id);
      chk($sformatf("v%0d_rsp", i), {rsp_exc, rsp_s, rsp_r}, {vt[i].exc, vt[i].s, vt[i].r});
      consume();
    end

    // Both requesters contend from reset: expect 0, 1, 0 spaced L+2 apart.
    do_reset();
    drive_req(0, 1, 4'hF, 16'h0001, 16'h0001);
    drive_req(1, 1, 4'hF, 16'h0002, 16'h0002);
    rsp_ready = 1'b1;
    drop = 1'b0;
    for (int c = 0; c < 40 && rid.size() < 3; c++) begin
      #1;
      chk("alt_both_ready", req0_ready & req1_ready, 0);
      if (req0_ready || req1_ready) begin
        g.push_back(int'(req1_ready));
        gc.push_back(c);
        if (g.size() == 3) drop = 1'b1;
      end
      if (rsp_valid) begin rid.push_back(int'(rsp_id)); rr.push_back(int'(rsp_r)); end
      @(negedge clk);
      if (drop) begin drive_req(0, 0, 4'hF, 16'h1, 16'h1); drive_req(1, 0, 4'hF, 16'h2, 16'h2); end
    end
    rsp_ready = 1'b0;
    eg = '{0, 1, 0};
    er = '{2, 4, 2};
    chk("alt_grant_count", g.size(), 3);
    chk("alt_rsp_count", rid.size(), 3);
    for (int i = 0; i < 3 && i < g.size(); i++) chk($sformatf("alt_grant%0d", i), g[i], eg[i]);
    for (int i = 0; i < 3 && i < rid.size(); i++) begin
      chk($sformatf("alt_rsp_id%0d", i), rid[i], eg[i]);
      chk($sformatf("alt_rsp_r%0d", i), rr[i], er[i]);
    end
    for (int i = 1; i < 3 && i < gc.size(); i++) chk($sformatf("alt_interval%0d", i), gc[i] - gc[i-1], SC + 2);

    // DIV by zero, then the response is held while the consumer stalls.
    issue(0, 4'h2, 16'h1234, 16'h0000);
    wait_rsp(4'h2, 16'h1234, 16'h0000, cyc);
    chk("div0_latency", cyc, MD + 1);
    drive_req(0, 1, 4'hF, 16'h0003, 16'h0003);
    drive_req(1, 1, 4'hF, 16'h0004, 16'h0004);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_rsp", {rsp_valid, rsp_id, rsp_exc, rsp_s, rsp_r}, {1'b1, 1'b0, 1'b1, 16'h1234, 16'hFFFF});
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    drive_req(0, 0, 4'hF, 16'h0, 16'h0);
    drive_req(1, 0, 4'hF, 16'h0, 16'h0);
    consume();

    // Reset two cycles into a MUL issued by requester 0.
    do_reset();
    issue(0, 4'h1, 16'h7FFF, 16'h0003);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rsp", {rsp_valid, rsp_id, rsp_exc, rsp_r, rsp_s}, 0);
    chk("mrst_alu", {alu_ctl, alu_a, alu_b}, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("mrst_no_rsp", rsp_valid, 0);
    end
    drive_req(0, 1, 4'hF, 16'h0010, 16'h0020);
    drive_req(1, 1, 4'hF, 16'h0030, 16'h0040);
    #1;
    chk("mrst_grant", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    drive_req(0, 0, 4'hF, 16'h0, 16'h0);
    drive_req(1, 0, 4'hF, 16'h0, 16'h0);
    wait_rsp(4'hF, 16'h0010, 16'h0020, cyc);
    chk("mrst_after_r", rsp_r, 16'h0030);
    consume();

    // Randomised traffic against a timeline model of grants and responses.
    do_reset();
    m_idle = 1; m_prio = 0; m_pend = 0; due = 0; m_id = 0; m_exp = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_ctl = 4'($urandom_range(0, 15));
      req1_ctl = 4'($urandom_range(0, 15));
      req0_a = 16'($urandom);
      req1_a = 16'($urandom);
      req0_b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      req1_b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e0 = 0; e1 = 0;
      if (m_idle && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) e1 = m_prio;
        else e1 = req1_valid;
        e0 = !e1;
      end
      chk("rnd_ready", {req0_ready, req1_ready}, {e0, e1});
      chk("rnd_busy", busy, !m_idle);
      chk("rnd_rsp_valid", rsp_valid, m_pend && c >= due);
      if (m_pend && c >= due) begin
        chk("rnd_rsp_id", rsp_id, m_id);
        chk("rnd_rsp", {rsp_exc, rsp_s, rsp_r}, m_exp);
      end
      if (e0 || e1) begin
        m_id = e1;
        m_prio = !e1;
        m_exp = e1 ? expect_rsp(req1_ctl, req1_a, req1_b) : expect_rsp(req0_ctl, req0_a, req0_b);
        due = c + lat(e1 ? req1_ctl : req0_ctl) + 1;
        m_pend = 1;
        m_idle = 0;
      end else if (m_pend && c >= due && rsp_ready) begin
        m_pend = 0;
        m_idle = 1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule
